// File: rtl/emgcy_preempt_arbiter.sv
// Round-robin emergency preemption arbiter: one grant at a time with min/max hold,
// lockout of requesters that time out, and an all-red clearance between grants.
module emgcy_preempt_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MIN_HOLD     = 4,
  parameter int MAX_HOLD     = 32,
  parameter int CLEAR_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] active_id,
  output logic                     emgcy_out,
  output logic                     timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int CW  = $clog2(CLEAR_CYCLES + 1);

  localparam logic [HW-1:0]  HOLD_MIN_LAST = HW'(MIN_HOLD - 1);
  localparam logic [HW-1:0]  HOLD_MAX_LAST = HW'(MAX_HOLD - 1);
  localparam logic [CW-1:0]  CLEAR_LAST    = CW'(CLEAR_CYCLES - 1);
  localparam logic [IDW-1:0] PTR_RESET     = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_CLEAR
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IDW-1:0]   r_activeId;
  logic             r_emgcyOut;
  logic             r_timeout;
  logic [HW-1:0]    r_holdCnt;
  logic [CW-1:0]    r_clearCnt;
  logic [N_REQ-1:0] r_lockout;
  logic [IDW-1:0]   r_ptr;

  state_t           w_nextState;
  logic [N_REQ-1:0] w_nextGrant;
  logic [IDW-1:0]   w_nextActiveId;
  logic             w_nextEmgcyOut;
  logic             w_nextTimeout;
  logic [HW-1:0]    w_nextHoldCnt;
  logic [CW-1:0]    w_nextClearCnt;
  logic [N_REQ-1:0] w_nextLockout;
  logic [N_REQ-1:0] w_lockSet;
  logic [IDW-1:0]   w_nextPtr;

  logic [N_REQ-1:0] w_elig;
  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [N_REQ-1:0] w_winnerOh;
  logic             w_activeReq;

  assign w_elig      = req & ~r_lockout;
  assign w_activeReq = req[r_activeId];

  // Search starts one past the last winner, so the most recent grantee has lowest priority.
  always_comb begin : pick
    logic [IDW-1:0] idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && w_elig[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_comb begin
    w_winnerOh           = '0;
    w_winnerOh[w_winner] = 1'b1;
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextGrant    = r_grant;
    w_nextActiveId = r_activeId;
    w_nextEmgcyOut = r_emgcyOut;
    w_nextTimeout  = 1'b0;
    w_nextHoldCnt  = r_holdCnt;
    w_nextClearCnt = r_clearCnt;
    w_nextPtr      = r_ptr;
    w_lockSet      = '0;

    unique case (r_state)
      S_IDLE: begin
        w_nextEmgcyOut = 1'b0;
        w_nextGrant    = '0;
        if (w_found) begin
          w_nextState    = S_HOLD;
          w_nextGrant    = w_winnerOh;
          w_nextActiveId = w_winner;
          w_nextPtr      = w_winner;
          w_nextHoldCnt  = '0;
          w_nextEmgcyOut = 1'b1;
        end
      end

      S_HOLD: begin
        w_nextEmgcyOut = 1'b1;
        if ((r_holdCnt >= HOLD_MIN_LAST) && !w_activeReq) begin
          w_nextState    = S_CLEAR;
          w_nextGrant    = '0;
          w_nextClearCnt = '0;
        end else if (r_holdCnt == HOLD_MAX_LAST) begin
          w_nextState           = S_CLEAR;
          w_nextGrant           = '0;
          w_nextClearCnt        = '0;
          w_nextTimeout         = 1'b1;
          w_lockSet[r_activeId] = 1'b1;
        end else begin
          w_nextHoldCnt = r_holdCnt + 1'b1;
        end
      end

      S_CLEAR: begin
        w_nextEmgcyOut = 1'b1;
        w_nextGrant    = '0;
        if (r_clearCnt == CLEAR_LAST) begin
          // Chaining straight into the next grant keeps emgcy_out high with no gap.
          if (w_found) begin
            w_nextState    = S_HOLD;
            w_nextGrant    = w_winnerOh;
            w_nextActiveId = w_winner;
            w_nextPtr      = w_winner;
            w_nextHoldCnt  = '0;
          end else begin
            w_nextState    = S_IDLE;
            w_nextEmgcyOut = 1'b0;
          end
        end else begin
          w_nextClearCnt = r_clearCnt + 1'b1;
        end
      end

      default: begin
        w_nextState    = S_IDLE;
        w_nextGrant    = '0;
        w_nextEmgcyOut = 1'b0;
      end
    endcase
  end

  // A locked requester is released only by dropping its request.
  assign w_nextLockout = (r_lockout & req) | w_lockSet;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_activeId <= '0;
      r_emgcyOut <= 1'b0;
      r_timeout  <= 1'b0;
      r_holdCnt  <= '0;
      r_clearCnt <= '0;
      r_lockout  <= '0;
      r_ptr      <= PTR_RESET;
    end else begin
      r_state    <= w_nextState;
      r_grant    <= w_nextGrant;
      r_activeId <= w_nextActiveId;
      r_emgcyOut <= w_nextEmgcyOut;
      r_timeout  <= w_nextTimeout;
      r_holdCnt  <= w_nextHoldCnt;
      r_clearCnt <= w_nextClearCnt;
      r_lockout  <= w_nextLockout;
      r_ptr      <= w_nextPtr;
    end
  end

  assign grant     = r_grant;
  assign active_id = r_activeId;
  assign emgcy_out = r_emgcyOut;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_emgcy_preempt_arbiter.sv
// Directed bench for emgcy_preempt_arbiter with default parameters
// (N_REQ=4, MIN_HOLD=4, MAX_HOLD=32, CLEAR_CYCLES=3).
module tb_emgcy_preempt_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] active_id;
  logic       emgcy_out;
  logic       timeout;

  int vectors;
  int miscompares;

  emgcy_preempt_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .grant     (grant),
    .active_id (active_id),
    .emgcy_out (emgcy_out),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic stepCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                             input logic expEmgcy, input logic expTimeout);
    vectors++;
    assert ({grant, emgcy_out, timeout} === {expGrant, expEmgcy, expTimeout})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed grant=%b emgcy=%b timeout=%b, expected grant=%b emgcy=%b timeout=%b",
             tag, grant, emgcy_out, timeout, expGrant, expEmgcy, expTimeout);
    end
  endtask

  task automatic checkId(input string tag, input logic [1:0] expId);
    vectors++;
    assert (active_id === expId)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed active_id=%0d, expected active_id=%0d", tag, active_id, expId);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] expG;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    req         = 4'b0000;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("reset_outputs", 4'b0000, 1'b0, 1'b0);
    checkId("reset_active_id", 2'd0);
    reset_n = 1'b1;
    stepCycle();
    checkOutput("idle_after_reset", 4'b0000, 1'b0, 1'b0);

    // Single-cycle pulse on req[1]: 4 grant cycles, 3 clear cycles, back to idle
    applyStimulus(4'b0010);
    stepCycle();
    checkOutput("pulse_grant_c0", 4'b0010, 1'b1, 1'b0);
    checkId("pulse_id", 2'd1);
    applyStimulus(4'b0000);
    for (int c = 1; c < 4; c++) begin
      stepCycle();
      checkOutput("pulse_grant_min_hold", 4'b0010, 1'b1, 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("pulse_clear", 4'b0000, 1'b1, 1'b0);
    end
    stepCycle();
    checkOutput("pulse_idle", 4'b0000, 1'b0, 1'b0);
    stepCycle();
    checkOutput("pulse_idle_stays", 4'b0000, 1'b0, 1'b0);

    // Two requesters: req[0] wins first, drops after 6 cycles, req[2] follows with no gap
    doReset();
    applyStimulus(4'b0101);
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      checkOutput("two_grant0", 4'b0001, 1'b1, 1'b0);
    end
    checkId("two_id0", 2'd0);
    applyStimulus(4'b0100);
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("two_clear", 4'b0000, 1'b1, 1'b0);
    end
    stepCycle();
    checkOutput("two_grant2", 4'b0100, 1'b1, 1'b0);
    checkId("two_id2", 2'd2);
    applyStimulus(4'b0000);

    // Held request times out after 32 cycles and is locked out while still high
    doReset();
    applyStimulus(4'b1000);
    for (int c = 0; c < 32; c++) begin
      stepCycle();
      checkOutput("max_hold_grant", 4'b1000, 1'b1, 1'b0);
    end
    checkId("max_hold_id", 2'd3);
    stepCycle();
    checkOutput("timeout_pulse", 4'b0000, 1'b1, 1'b1);
    stepCycle();
    checkOutput("timeout_clear2", 4'b0000, 1'b1, 1'b0);
    stepCycle();
    checkOutput("timeout_clear3", 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 13; c++) begin
      stepCycle();
      checkOutput("lockout_idle", 4'b0000, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000);
    stepCycle();
    checkOutput("lockout_drop", 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000);
    stepCycle();
    checkOutput("lockout_regrant", 4'b1000, 1'b1, 1'b0);
    checkId("lockout_regrant_id", 2'd3);
    applyStimulus(4'b0000);

    // All four requesting: rotation 0001, 0010, 0100, 1000, 0001
    doReset();
    applyStimulus(4'b1111);
    for (int g = 0; g < 5; g++) begin
      expG = 4'b0001 << (g % 4);
      for (int c = 0; c < 5; c++) begin
        stepCycle();
        checkOutput("rr_grant", expG, 1'b1, 1'b0);
      end
      checkId("rr_id", 2'(g % 4));
      if (g < 4) begin
        applyStimulus(req & ~expG);
        stepCycle();
        checkOutput("rr_clear1", 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b1111);
        stepCycle();
        checkOutput("rr_clear2", 4'b0000, 1'b1, 1'b0);
        stepCycle();
        checkOutput("rr_clear3", 4'b0000, 1'b1, 1'b0);
      end
    end
    applyStimulus(4'b0000);

    // Asynchronous reset during a grant, then lowest eligible index wins
    doReset();
    applyStimulus(4'b0100);
    stepCycle();
    checkOutput("async_pre_grant", 4'b0100, 1'b1, 1'b0);
    stepCycle();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_now", 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0110);
    stepCycle();
    checkOutput("async_held", 4'b0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    stepCycle();
    checkOutput("async_post_grant", 4'b0010, 1'b1, 1'b0);
    checkId("async_post_id", 2'd1);
    applyStimulus(4'b0000);
    stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
